// File: rtl/qam_mod_pkg.sv
// Shared definitions for the multi-order QAM modulator: mode codes, per-mode sizing, Gray decode.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. Optional upconverter in qam_mod_param is enabled by QAM_MOD_UPCONV_EN.
package qam_mod_pkg;

    localparam logic [1:0] MODE_QPSK  = 2'd0;
    localparam logic [1:0] MODE_16QAM = 2'd1;
    localparam logic [1:0] MODE_64QAM = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bits per symbol; the reserved code falls back to QPSK.
    function automatic logic [2:0] bps_of(input logic [1:0] mode);
        case (mode)
            MODE_QPSK:  return 3'd2;
            MODE_16QAM: return 3'd4;
            MODE_64QAM: return 3'd6;
            default:    return 3'd2;
        endcase
    endfunction

    // Symbols needed to carry a frame; a partial last symbol counts as one.
    function automatic int nsym_of(input logic [1:0] mode, input int frame_w);
        int bps;
        bps = int'(bps_of(mode));
        return (frame_w + bps - 1) / bps;
    endfunction

    function automatic logic [2:0] gray_to_bin(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

endpackage

// File: rtl/qam_axis_mapper.sv
// Maps a right-aligned Gray field of k bits (1..3) to a signed, scaled constellation level.
// Latency: combinational.
// Backpressure: none.
module qam_axis_mapper
    import qam_mod_pkg::*;
#(
    parameter int AMP_W    = 9,
    parameter int AMP_STEP = 16
) (
    input  logic [2:0]              fld,
    input  logic [1:0]              k,
    output logic signed [AMP_W-1:0] level
);

    logic [2:0]        n;
    logic signed [4:0] odd;
    int                prod;

    // Gray code -> natural index n -> odd integer 2n-(2^k-1) -> scaled level
    always_comb begin
        n = gray_to_bin(fld);
        case (k)
            2'd2:    odd = $signed({1'b0, n, 1'b0}) - 5'sd3;
            2'd3:    odd = $signed({1'b0, n, 1'b0}) - 5'sd7;
            default: odd = $signed({1'b0, n, 1'b0}) - 5'sd1;
        endcase
        prod  = int'(odd) * AMP_STEP;
        level = AMP_W'(prod);
    end

endmodule

// File: rtl/qam_mod_param.sv
// QPSK/16QAM/64QAM frame modulator with a two-slot frame buffer; optional 4-phase upconverter (QAM_MOD_UPCONV_EN).
// Latency: first symbol strobes the cycle after an idle accept; SYM_DIV clocks per symbol, no gap between frames.
// Backpressure: in_ready is a registered "buffer not full" flag; a pop re-opens it on the following cycle.
module qam_mod_param
    import qam_mod_pkg::*;
#(
    parameter int FRAME_W  = 128,
    parameter int AMP_W    = 9,
    parameter int AMP_STEP = 16,
    parameter int SYM_DIV  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FRAME_W-1:0]      in_data,
    input  logic [1:0]              in_mode,
    output logic                    sym_strobe,
    output logic signed [AMP_W-1:0] i_out,
    output logic signed [AMP_W-1:0] q_out,
    output logic                    busy,
    output logic                    frame_done
`ifdef QAM_MOD_UPCONV_EN
    ,
    output logic signed [AMP_W-1:0] mod_out
`endif
);

    localparam int PTR_W  = $clog2(FRAME_W + 6);
    localparam int NSYM_W = $clog2(FRAME_W / 2 + 1);
    localparam int CNT_W  = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;

    // Frame buffer
    logic [FRAME_W-1:0] slot_dat  [2];
    logic [1:0]         slot_mode [2];
    logic [1:0]         slot_vld;
    logic [1:0]         vld_nxt;
    logic               wr_ptr;
    logic               rd_ptr;

    // Frame / symbol sequencing
    state_t             state;
    state_t             state_nxt;
    logic [2:0]         cur_bps;
    logic [NSYM_W-1:0]  sym_idx;
    logic [NSYM_W-1:0]  last_idx;
    logic [PTR_W-1:0]   nxt_ptr;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               head_vld;
    logic               wrap;
    logic               load;
    logic               start;
    logic               stop;
    logic               is_last;
    logic               pop;
    logic [FRAME_W-1:0] src_dat;
    logic [1:0]         src_mode;
    logic [2:0]         bps_use;
    logic [PTR_W-1:0]   ptr_use;
    logic [PTR_W-1:0]   sel_hi;
    logic [NSYM_W-1:0]  idx_use;
    logic [NSYM_W-1:0]  last_use;
    logic [FRAME_W+5:0] ext;
    logic [5:0]         field;
    logic [1:0]         k_use;
    logic [2:0]         i_fld;
    logic [2:0]         q_fld;
    logic signed [AMP_W-1:0] i_lvl;
    logic signed [AMP_W-1:0] q_lvl;

    assign accept   = in_valid & in_ready;
    assign head_vld = slot_vld[rd_ptr];
    // An empty buffer means wr_ptr == rd_ptr, so a frame arriving now can be
    // started straight from the input while it is also written to the slot.
    assign src_dat  = head_vld ? slot_dat[rd_ptr]  : in_data;
    assign src_mode = head_vld ? slot_mode[rd_ptr] : in_mode;
    assign wrap     = (cnt == CNT_W'(SYM_DIV - 1));

    // Next-state: decide whether this edge loads a symbol, starts a frame or goes idle
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_RUN;
                    load      = 1'b1;
                    start     = 1'b1;
                end
            end
            ST_RUN: begin
                if (wrap) begin
                    if (sym_idx != last_idx) begin
                        load = 1'b1;
                    end else if (head_vld || accept) begin
                        load  = 1'b1;
                        start = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        stop      = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Extract the next symbol's bits MSB-first and split them across I and Q
    always_comb begin
        bps_use  = start ? bps_of(src_mode) : cur_bps;
        ptr_use  = start ? '0 : nxt_ptr;
        idx_use  = start ? '0 : sym_idx + 1'b1;
        last_use = start ? NSYM_W'(nsym_of(src_mode, FRAME_W) - 1) : last_idx;
        is_last  = (idx_use == last_use);
        pop      = load & is_last;
        // Six zero bits below the frame supply the missing LSBs of a partial last symbol.
        ext      = {src_dat, 6'b0};
        sel_hi   = PTR_W'(FRAME_W + 5) - ptr_use;
        field    = ext[sel_hi -: 6];
        k_use    = bps_use[2:1];
        case (k_use)
            2'd2: begin
                i_fld = {1'b0, field[5:4]};
                q_fld = {1'b0, field[3:2]};
            end
            2'd3: begin
                i_fld = field[5:3];
                q_fld = field[2:0];
            end
            default: begin
                i_fld = {2'b0, field[5]};
                q_fld = {2'b0, field[4]};
            end
        endcase
    end

    // Slot occupancy after this edge's write and pop
    always_comb begin
        vld_nxt = slot_vld;
        if (accept) vld_nxt[wr_ptr] = 1'b1;
        if (pop)    vld_nxt[rd_ptr] = 1'b0;
    end

    qam_axis_mapper #(.AMP_W(AMP_W), .AMP_STEP(AMP_STEP)) u_map_i (
        .fld   (i_fld),
        .k     (k_use),
        .level (i_lvl)
    );

    qam_axis_mapper #(.AMP_W(AMP_W), .AMP_STEP(AMP_STEP)) u_map_q (
        .fld   (q_fld),
        .k     (k_use),
        .level (q_lvl)
    );

    // Ping-pong buffer: write on accept, release the head when its last symbol is loaded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_vld     <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            in_ready     <= 1'b1;
            slot_dat[0]  <= '0;
            slot_dat[1]  <= '0;
            slot_mode[0] <= '0;
            slot_mode[1] <= '0;
        end else begin
            slot_vld <= vld_nxt;
            in_ready <= ~&vld_nxt;
            if (accept) begin
                slot_dat[wr_ptr]  <= in_data;
                slot_mode[wr_ptr] <= in_mode;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end

    // FSM state, symbol divider and per-frame bit pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cur_bps  <= '0;
            sym_idx  <= '0;
            last_idx <= '0;
            nxt_ptr  <= '0;
        end else begin
            state <= state_nxt;
            if (load || stop) begin
                cnt <= '0;
            end else if (state == ST_RUN) begin
                cnt <= cnt + 1'b1;
            end
            if (load) begin
                cur_bps  <= bps_use;
                sym_idx  <= idx_use;
                last_idx <= last_use;
                nxt_ptr  <= ptr_use + PTR_W'(bps_use);
            end
        end
    end

    // Registered symbol outputs: levels held for the symbol, zeroed when going idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_strobe <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            i_out      <= '0;
            q_out      <= '0;
        end else begin
            sym_strobe <= load;
            frame_done <= pop;
            busy       <= (state_nxt == ST_RUN);
            if (load) begin
                i_out <= i_lvl;
                q_out <= q_lvl;
            end else if (stop) begin
                i_out <= '0;
                q_out <= '0;
            end
        end
    end

`ifdef QAM_MOD_UPCONV_EN
    logic [1:0] phase;

    // Two's-complement negation clipped so the most negative code maps to the maximum
    function automatic logic signed [AMP_W-1:0] sat_neg(input logic signed [AMP_W-1:0] v);
        if (v == {1'b1, {(AMP_W-1){1'b0}}}) return {1'b0, {(AMP_W-1){1'b1}}};
        return -v;
    endfunction

    // Quarter-rate carrier: I*cos - Q*sin sampled at 0/90/180/270 degrees, phase 0 on each strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase   <= 2'd0;
            mod_out <= '0;
        end else begin
            if (load) begin
                phase <= 2'd0;
            end else if (state == ST_RUN) begin
                phase <= phase + 2'd1;
            end
            if (!busy) begin
                mod_out <= '0;
            end else begin
                case (phase)
                    2'd0:    mod_out <= i_out;
                    2'd1:    mod_out <= sat_neg(q_out);
                    2'd2:    mod_out <= sat_neg(i_out);
                    default: mod_out <= q_out;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_qam_mod_param.sv
// Directed bench for qam_mod_param: table of frames with hand-derived symbol levels,
// plus back-to-back, mid-frame reset and (when QAM_MOD_UPCONV_EN is set) upconverter sequences.
module tb_qam_mod_param;

    localparam int FW   = 128;
    localparam int AW   = 9;
    localparam int STEP = 16;
    localparam int SD   = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [FW-1:0]        in_data;
    logic [1:0]           in_mode;
    logic                 sym_strobe;
    logic signed [AW-1:0] i_out;
    logic signed [AW-1:0] q_out;
    logic                 busy;
    logic                 frame_done;
`ifdef QAM_MOD_UPCONV_EN
    logic signed [AW-1:0] mod_out;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    qam_mod_param #(.FRAME_W(FW), .AMP_W(AW), .AMP_STEP(STEP), .SYM_DIV(SD)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .sym_strobe (sym_strobe),
        .i_out      (i_out),
        .q_out      (q_out),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef QAM_MOD_UPCONV_EN
        ,
        .mod_out    (mod_out)
`endif
    );

    typedef struct {
        logic [1:0]    mode;
        logic [FW-1:0] data;
        int            nsym;
        int            i0, q0;   // symbol 0
        int            i1, q1;   // symbol 1
        int            im, qm;   // symbols 2 .. nsym-2
        int            il, ql;   // last symbol
    } vec_t;

    vec_t vecs [6];

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one frame and hold it until accepted; returns in the cycle after the accept.
    task automatic push(input logic [1:0] m, input logic [FW-1:0] d);
        int wt;
        wt       = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        while (!in_ready && wt < 2000) begin
            step();
            wt++;
        end
        chk("push_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
    endtask

    // Follow one frame's symbols; cont=1 means its first strobe must follow the
    // previous frame's last strobe by exactly SD cycles.
    task automatic collect(input vec_t v, input bit cont, input string tag);
        int wt;
        int extra;
        int ei;
        int eq;
        extra = 0;
        if (!cont) begin
            wt = 0;
            while (!sym_strobe && wt < 100) begin
                step();
                wt++;
            end
        end
        for (int s = 0; s < v.nsym; s++) begin
            if (s > 0 || cont) begin
                for (int c = 1; c < SD; c++) begin
                    step();
                    if (sym_strobe) extra++;
                end
                step();
            end
            if (s == 0) begin
                ei = v.i0; eq = v.q0;
            end else if (s == 1) begin
                ei = v.i1; eq = v.q1;
            end else if (s == v.nsym - 1) begin
                ei = v.il; eq = v.ql;
            end else begin
                ei = v.im; eq = v.qm;
            end
            chk($sformatf("%s_strobe%0d", tag, s), int'(sym_strobe), 1);
            chk($sformatf("%s_i%0d", tag, s), i_out, ei);
            chk($sformatf("%s_q%0d", tag, s), q_out, eq);
            chk($sformatf("%s_done%0d", tag, s), int'(frame_done), (s == v.nsym - 1) ? 1 : 0);
        end
        chk($sformatf("%s_extra_strobes", tag), extra, 0);
    endtask

    // The cycle after the last symbol period of a final frame is idle with zero outputs.
    task automatic check_idle_after(input string tag);
        repeat (SD) step();
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_idle_i"}, i_out, 0);
        chk({tag, "_idle_q"}, q_out, 0);
        chk({tag, "_idle_strobe"}, int'(sym_strobe), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        int wt;
        int strobes;
        int mexp [4];

        vecs[0] = '{2'd0, {8'hC0, 120'h0},          64,  16,  16, -16, -16, -16, -16,  -16,  -16};
        vecs[1] = '{2'd1, {8'h2D, 120'h0},          32, -48,  48,  16, -16, -48, -48,  -48,  -48};
        vecs[2] = '{2'd2, {128{1'b1}},              22,  48,  48,  48,  48,  48,  48,   16, -112};
        vecs[3] = '{2'd3, {8'h80, 112'h0, 8'h01},   64,  16, -16, -16, -16, -16, -16,  -16,   16};
        vecs[4] = '{2'd2, {12'h5A0, 116'h0},        22, -16,  16, 112, -112, -112, -112, -112, -112};
        vecs[5] = '{2'd1, {8'hB7, 120'h0},          32,  48,  16, -16,  16, -48, -48,  -48,  -48};
        mexp    = '{16, 16, -16, -16};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_mode  = 2'd0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobe", int'(sym_strobe), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_i", i_out, 0);
        chk("rst_q", q_out, 0);
`ifdef QAM_MOD_UPCONV_EN
        chk("rst_mod", mod_out, 0);
`endif

        // Single frames from the table, each started from idle
        for (int n = 0; n < 6; n++) begin
            push(vecs[n].mode, vecs[n].data);
            chk($sformatf("v%0d_start_latency", n), int'(sym_strobe), 1);
            collect(vecs[n], 1'b0, $sformatf("v%0d", n));
            check_idle_after($sformatf("v%0d", n));
        end

        // Three frames back-to-back with in_valid held: no gap, per-frame modes
        fork
            begin
                push(vecs[0].mode, vecs[0].data);
                push(vecs[2].mode, vecs[2].data);
                chk("b2b_ready_full", int'(in_ready), 0);
                in_valid = 1'b1;
                in_mode  = vecs[1].mode;
                in_data  = vecs[1].data;
                early    = 0;
                wt       = 0;
                while (!frame_done && wt < 1000) begin
                    if (in_ready) early++;
                    step();
                    wt++;
                end
                chk("b2b_ready_low_until_done", early, 0);
                chk("b2b_first_done", int'(frame_done), 1);
                chk("b2b_ready_at_done", int'(in_ready), 1);
                step();
                in_valid = 1'b0;
            end
            begin
                collect(vecs[0], 1'b0, "b2b_f1");
                collect(vecs[2], 1'b1, "b2b_f2");
                collect(vecs[1], 1'b1, "b2b_f3");
                check_idle_after("b2b");
            end
        join

        // Reset in the middle of a symbol with a second frame buffered
        push(2'd0, {128{1'b1}});
        push(2'd0, {128{1'b1}});
        repeat (10) step();
        chk("mid_pre_i", i_out, 16);
        chk("mid_pre_busy", int'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_i", i_out, 0);
        chk("mid_rst_q", q_out, 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        @(posedge clk);
        #3;
        reset   = 1'b0;
        strobes = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (sym_strobe) strobes++;
        end
        chk("post_rst_strobes", strobes, 0);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_ready", int'(in_ready), 1);

        // New frame after reset: first symbol (+16,-16)
        push(vecs[3].mode, vecs[3].data);
        chk("recover_strobe", int'(sym_strobe), 1);
        chk("recover_i", i_out, 16);
        chk("recover_q", q_out, -16);
`ifdef QAM_MOD_UPCONV_EN
        for (int p = 0; p < 4; p++) begin
            step();
            chk($sformatf("upconv_p%0d", p), mod_out, mexp[p]);
        end
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
